// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Collects two N-bit operands from a W-bit chunk stream (least significant
// chunk first), then a 4-bit opcode, presents them to a combinational ALU,
// captures the result and flags for one cycle, and holds them until the
// consumer takes them with a valid/ready handshake.
//
// Optional feature: define ALU_SEQ_STICKY_EN to accumulate the V and C flags
// of every executed operation into sticky_vc. The accumulated value is
// cleared only by rst. Without the macro, sticky_vc is tied to 2'b00.
module alu_operand_sequencer #(
    parameter int N = 128,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic [1:0]   sticky_vc
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        EXEC,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          last_chunk;

    assign xfer       = in_valid & in_ready;
    assign last_chunk = (cnt == CW'(K - 1));

    // Sequencer FSM: operand/opcode loading, one-cycle execute, result hold.
    // in_ready is registered, so it stays low while rst is high and rises on
    // the first edge after release.
    // NOTE: every register here is assigned with <= so that all of them
    // update together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD_A;
            cnt         <= '0;
            in_ready    <= 1'b0;
            a           <= '0;
            b           <= '0;
            alu_control <= 4'h0;
            result      <= '0;
            flags       <= 4'h0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        a[cnt*W +: W] <= in_data;
                        if (last_chunk) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        b[cnt*W +: W] <= in_data;
                        if (last_chunk) begin
                            cnt   <= '0;
                            state <= LOAD_OP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_OP: begin
                    if (xfer) begin
                        // Only the low nibble is an opcode; upper bits are ignored.
                        alu_control <= in_data[3:0];
                        in_ready    <= 1'b0;
                        state       <= EXEC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    result    <= alu_result;
                    flags     <= {alu_z, alu_n, alu_v, alu_c};
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    cnt       <= '0;
                    state     <= LOAD_A;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STICKY_EN
    logic [1:0] sticky_q;

    // Accumulate V and C across operations; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else if (state == EXEC) begin
            sticky_q <= sticky_q | {alu_v, alu_c};
        end
    end

    assign sticky_vc = sticky_q;
`else
    assign sticky_vc = 2'b00;
`endif

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameters SHALL be:
- N, default 128, operand/result width.
- W, default 8, input chunk width; N SHALL be an integer multiple of W, with K = N/W.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  chunk/opcode available on in_data.
- in_ready  out  1  sequencer accepts in_data this cycle.
- in_data  in  W  operand chunk, or opcode in bits [3:0].
- a  out  N  operand A to ALU.
- b  out  N  operand B to ALU.
- alu_control  out  4  opcode to ALU.
- alu_result  in  N  combinational ALU result.
- alu_z, alu_n, alu_v, alu_c  in  1 each  ALU flags.
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer accepts the result.
- result  out  N  captured result.
- flags  out  4  captured {Z,N,V,C}.
- sticky_vc  out  2  accumulated {V,C}; see Configuration.

Function
REQ-003 A transfer SHALL occur on a cycle where in_valid and in_ready are both 1; res handoff SHALL occur where res_valid and res_ready are both 1.
REQ-004 FSM states SHALL be LOAD_A, LOAD_B, LOAD_OP, EXEC, HOLD; in_ready=1 only in LOAD_A, LOAD_B and LOAD_OP.
REQ-005 LOAD_A SHALL accept K chunks, least significant first; chunk i SHALL be written to a[i*W +: W]; after chunk K-1, go to LOAD_B.
REQ-006 LOAD_B SHALL load b identically; after chunk K-1, go to LOAD_OP.
REQ-007 LOAD_OP SHALL accept one transfer, latch in_data[3:0] into alu_control (upper bits ignored), then go to EXEC.
REQ-008 A chunk counter SHALL be ceil(log2 K) bits, SHALL reset to 0 on entering each LOAD_A/LOAD_B, and SHALL NOT wrap past K-1.
REQ-009 Cycles without a transfer SHALL leave all registers and state unchanged; no timeout.
REQ-010 a, b and alu_control SHALL remain stable from the LOAD_OP transfer through the end of HOLD.
REQ-011 EXEC SHALL last exactly one cycle, capturing alu_result into result and {alu_z,alu_n,alu_v,alu_c} into flags on that cycle's closing edge, then go to HOLD.
REQ-012 HOLD SHALL assert res_valid=1 and keep result/flags stable until handoff; on handoff, go to LOAD_A with res_valid=0 on the next cycle.
REQ-013 res_ready SHALL be ignored outside HOLD; in_valid SHALL be ignored in EXEC and HOLD.
REQ-014 Latency from the LOAD_OP transfer to res_valid=1 SHALL be exactly 2 cycles.
REQ-015 Back-to-back operation: LOAD_A SHALL accept a chunk on the cycle after a handoff; throughput SHALL be 2K+3 cycles per operation with in_valid and res_ready held at 1.
REQ-016 a and b SHALL NOT be cleared between operations; each is overwritten chunk by chunk.

Reset
REQ-017 Asserting rst SHALL immediately force, in any state including mid-load or HOLD:
- state=LOAD_A, counter=0;
- a, b, result = 0; alu_control, flags = 0;
- sticky_vc = 0, res_valid = 0.
REQ-018 in_ready SHALL be 0 while rst=1, and SHALL be 1 on the first clock edge after deassertion.

Configuration
REQ-019 With macro ALU_SEQ_STICKY_EN defined, sticky_vc SHALL OR in {alu_v,alu_c} at each EXEC capture; it SHALL clear only on rst.
REQ-020 Without ALU_SEQ_STICKY_EN, the sticky_vc port SHALL remain present and be tied to 2'b00, with no accumulator registers.

Verification (N=128, W=8, bench ALU stub drives alu_result=a+b and flags={0,0,1,1})
REQ-021 Send 16 chunks 0x01..0x10, 16 chunks 0xFF, then opcode 0x52 -> a=0x100F...0201, b=all ones, alu_control=4'h2, res_valid=1 two cycles after the opcode transfer, result=a+b mod 2^128, flags=4'b0011.
REQ-022 Hold res_ready=0 for 10 cycles in HOLD, with in_valid=1 -> in_ready=0, result stable, a/b unchanged; on res_ready=1, one handoff, then LOAD_A.
REQ-023 Toggle in_valid every cycle during the loads -> only valid cycles advance the counter; final a/b identical to REQ-021.
REQ-024 Assert rst asynchronously after 7 B chunks -> all outputs 0 before the next edge; a fresh full sequence completes correctly.
REQ-025 Run two operations with the macro defined -> sticky_vc=2'b11 after the first and stays 2'b11; without the macro -> sticky_vc=2'b00 throughout.
REQ-026 With in_valid and res_ready tied to 1 -> handoffs exactly 35 cycles apart.
